reg_read_stage: RTL and testbench

REG_READ_STAGE -- requirements
Module: reg_read_stage

---
 rtl/reg_read_stage.sv | 166 ++++++++++++++++
 tb/tb_reg_read_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: register file with write-back bypass, busy-bit
// scoreboard for RAW/WAW hazard stalls, and a one-entry output register.
module reg_read_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int FUR_W    = 48,
    parameter int ZERO_REG = 1,
    localparam int RIDX_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RIDX_W-1:0] in_rs1,
    input  logic [RIDX_W-1:0] in_rs2,
    input  logic              in_rs1_en,
    input  logic              in_rs2_en,
    input  logic              in_wb_wr,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic [FUR_W-1:0]  in_fur,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic              out_wb_wr,
    output logic [RIDX_W-1:0] out_rd,
    output logic [FUR_W-1:0]  out_fur,

    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    input  logic              flush
);

    typedef enum logic {
        REG_NOPE = 1'b0,
        REG_NEXT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      rf_q [NUM_REGS];
    logic [XLEN-1:0]      rf_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q, busy_d;

    logic [XLEN-1:0]      out_rs1_val_q, out_rs1_val_d;
    logic [XLEN-1:0]      out_rs2_val_q, out_rs2_val_d;
    logic                 out_wb_wr_q, out_wb_wr_d;
    logic [RIDX_W-1:0]    out_rd_q, out_rd_d;
    logic [FUR_W-1:0]     out_fur_q, out_fur_d;

    logic                 wb_zero;
    logic                 wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic                 raw_hazard, waw_hazard;
    logic                 fire;
    logic                 rd_is_zero;
    logic [XLEN-1:0]      rs1_val, rs2_val;

    // Hazard detection; a write-back landing this cycle resolves the hazard.
    always_comb begin
        wb_zero    = (ZERO_REG != 0) && (wb_rd == '0);
        wb_hit_rs1 = wb_valid && (wb_rd == in_rs1) && !wb_zero;
        wb_hit_rs2 = wb_valid && (wb_rd == in_rs2) && !wb_zero;
        wb_hit_rd  = wb_valid && (wb_rd == in_rd) && !wb_zero;
        rd_is_zero = (ZERO_REG != 0) && (in_rd == '0);

        raw_hazard = (in_rs1_en && busy_q[in_rs1] && !wb_hit_rs1) ||
                     (in_rs2_en && busy_q[in_rs2] && !wb_hit_rs2);
        waw_hazard = in_wb_wr && busy_q[in_rd] && !wb_hit_rd;

        in_ready = !flush && !raw_hazard && !waw_hazard &&
                   ((state_q == REG_NOPE) || out_ready);
        fire     = in_valid && in_ready;
    end

    always_comb begin
        rs1_val = '0;
        if (in_rs1_en) begin
            if (wb_hit_rs1)
                rs1_val = wb_data;
            else if (!((ZERO_REG != 0) && (in_rs1 == '0)))
                rs1_val = rf_q[in_rs1];
        end

        rs2_val = '0;
        if (in_rs2_en) begin
            if (wb_hit_rs2)
                rs2_val = wb_data;
            else if (!((ZERO_REG != 0) && (in_rs2 == '0)))
                rs2_val = rf_q[in_rs2];
        end
    end

    // Busy set from an issuing writer is applied last so it beats a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid && !wb_zero)
            busy_d[wb_rd] = 1'b0;
        if (fire && in_wb_wr && !rd_is_zero)
            busy_d[in_rd] = 1'b1;
        if (flush)
            busy_d = '0;

        rf_d = rf_q;
        if (wb_valid && !wb_zero)
            rf_d[wb_rd] = wb_data;
    end

    always_comb begin
        state_d       = state_q;
        out_rs1_val_d = out_rs1_val_q;
        out_rs2_val_d = out_rs2_val_q;
        out_wb_wr_d   = out_wb_wr_q;
        out_rd_d      = out_rd_q;
        out_fur_d     = out_fur_q;

        if (fire) begin
            out_rs1_val_d = rs1_val;
            out_rs2_val_d = rs2_val;
            out_wb_wr_d   = in_wb_wr;
            out_rd_d      = in_rd;
            out_fur_d     = in_fur;
        end

        case (state_q)
            REG_NOPE: if (fire) state_d = REG_NEXT;
            REG_NEXT: if (out_ready && !fire) state_d = REG_NOPE;
            default:  state_d = REG_NOPE;
        endcase

        if (flush)
            state_d = REG_NOPE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REG_NOPE;
            rf_q          <= '{default: '0};
            busy_q        <= '0;
            out_rs1_val_q <= '0;
            out_rs2_val_q <= '0;
            out_wb_wr_q   <= 1'b0;
            out_rd_q      <= '0;
            out_fur_q     <= '0;
        end else begin
            state_q       <= state_d;
            rf_q          <= rf_d;
            busy_q        <= busy_d;
            out_rs1_val_q <= out_rs1_val_d;
            out_rs2_val_q <= out_rs2_val_d;
            out_wb_wr_q   <= out_wb_wr_d;
            out_rd_q      <= out_rd_d;
            out_fur_q     <= out_fur_d;
        end
    end

    assign out_valid   = (state_q == REG_NEXT);
    assign out_rs1_val = out_rs1_val_q;
    assign out_rs2_val = out_rs2_val_q;
    assign out_wb_wr   = out_wb_wr_q;
    assign out_rd      = out_rd_q;
    assign out_fur     = out_fur_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed testbench for reg_read_stage: bypass, hazard stalls, backpressure,
// flush and asynchronous reset, each scenario checked in its own task.
module tb_reg_read_stage;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int FUR_W    = 48;
    localparam int RIDX_W   = $clog2(NUM_REGS);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [RIDX_W-1:0] in_rs1;
    logic [RIDX_W-1:0] in_rs2;
    logic              in_rs1_en;
    logic              in_rs2_en;
    logic              in_wb_wr;
    logic [RIDX_W-1:0] in_rd;
    logic [FUR_W-1:0]  in_fur;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;
    logic              out_wb_wr;
    logic [RIDX_W-1:0] out_rd;
    logic [FUR_W-1:0]  out_fur;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;

    int n_checks = 0;
    int n_fail   = 0;

    reg_read_stage #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .FUR_W(FUR_W), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
        .in_wb_wr(in_wb_wr), .in_rd(in_rd), .in_fur(in_fur),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_wb_wr(out_wb_wr), .out_rd(out_rd), .out_fur(out_fur),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rs1_en = 1'b0;
        in_rs2_en = 1'b0;
        in_wb_wr  = 1'b0;
        in_rd     = '0;
        in_fur    = '0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        n_checks++;
        if (out_rs1_val !== '0 || out_rs2_val !== '0 || out_rd !== '0 ||
            out_wb_wr !== 1'b0 || out_fur !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got rs1=%h rs2=%h rd=%0d wr=%0b fur=%h exp=all zero",
                     out_rs1_val, out_rs2_val, out_rd, out_wb_wr, out_fur);
        end
        #10;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
    endtask

    task automatic test_wb_then_read();
        step();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        idle();
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0;
        in_rs1_en = 1'b1; in_rs2_en = 1'b1; in_rd = 5'd1;
        in_fur = 48'h1234_5678_9ABC;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL read5_in_ready got=%0b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'hDEAD_BEEF || out_rs2_val !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL read5_out got v=%0b rs1=%h rs2=%h exp v=1 rs1=deadbeef rs2=0",
                     out_valid, out_rs1_val, out_rs2_val);
        end
        n_checks++;
        if (out_fur !== 48'h1234_5678_9ABC || out_wb_wr !== 1'b0 || out_rd !== 5'd1) begin
            n_fail++;
            $display("[TB] FAIL read5_passthru got fur=%h wr=%0b rd=%0d exp fur=123456789abc wr=0 rd=1",
                     out_fur, out_wb_wr, out_rd);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_rs1_val !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("[TB] FAIL drain_hold got v=%0b rs1=%h exp v=0 rs1=deadbeef",
                     out_valid, out_rs1_val);
        end
    endtask

    task automatic test_bypass_and_zero();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_CAFE;
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs1_en = 1'b1;
        in_rs2 = 5'd6; in_rs2_en = 1'b1;
        step();
        idle();
        n_checks++;
        if (out_rs1_val !== 32'h0 || out_rs2_val !== 32'h0000_CAFE) begin
            n_fail++;
            $display("[TB] FAIL bypass_zero got rs1=%h rs2=%h exp rs1=0 rs2=0000cafe",
                     out_rs1_val, out_rs2_val);
        end
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs1_en = 1'b0;
        in_rs2 = 5'd6; in_rs2_en = 1'b1;
        step();
        idle();
        n_checks++;
        if (out_rs1_val !== 32'h0 || out_rs2_val !== 32'h0000_CAFE) begin
            n_fail++;
            $display("[TB] FAIL disabled_src got rs1=%h rs2=%h exp rs1=0 rs2=0000cafe",
                     out_rs1_val, out_rs2_val);
        end
        step();
    endtask

    task automatic test_raw_stall();
        idle();
        in_valid = 1'b1; in_wb_wr = 1'b1; in_rd = 5'd7;
        step();
        idle();
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs1_en = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL raw_stall_0 got=%0b exp=0", in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL raw_stall_1 got rdy=%0b v=%0b exp rdy=0 v=0", in_ready, out_valid);
        end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h11;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL raw_release got=%0b exp=1", in_ready);
        end
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h11) begin
            n_fail++;
            $display("[TB] FAIL raw_value got v=%0b rs1=%h exp v=1 rs1=11", out_valid, out_rs1_val);
        end
        step();
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs1_en = 1'b1; in_fur = 48'hA;
        step();
        out_ready = 1'b0;
        in_rs1 = 5'd5; in_fur = 48'hB;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_rs1_val !== 32'h11 || out_fur !== 48'hA) begin
                n_fail++;
                $display("[TB] FAIL hold_%0d got rdy=%0b v=%0b rs1=%h fur=%h exp rdy=0 v=1 rs1=11 fur=a",
                         i, in_ready, out_valid, out_rs1_val, out_fur);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_release got=%0b exp=1", in_ready);
        end
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'hDEAD_BEEF || out_fur !== 48'hB) begin
            n_fail++;
            $display("[TB] FAIL bp_next got v=%0b rs1=%h fur=%h exp v=1 rs1=deadbeef fur=b",
                     out_valid, out_rs1_val, out_fur);
        end
        step();
    endtask

    task automatic test_back_to_back_waw();
        idle();
        in_valid = 1'b1; in_wb_wr = 1'b1; in_rd = 5'd3; in_fur = 48'hA1;
        step();
        in_fur = 48'hB2;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL waw_stall_0 got=%0b exp=0", in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL waw_stall_1 got=%0b exp=0", in_ready);
        end
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL waw_release got=%0b exp=1", in_ready);
        end
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_wb_wr !== 1'b1 || out_rd !== 5'd3 || out_fur !== 48'hB2) begin
            n_fail++;
            $display("[TB] FAIL waw_out got v=%0b wr=%0b rd=%0d fur=%h exp v=1 wr=1 rd=3 fur=b2",
                     out_valid, out_wb_wr, out_rd, out_fur);
        end
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs1_en = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL waw_busy_kept got=%0b exp=0", in_ready);
        end
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h44;
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h44) begin
            n_fail++;
            $display("[TB] FAIL waw_bypass got v=%0b rs1=%h exp v=1 rs1=44", out_valid, out_rs1_val);
        end
        step();
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1'b1; in_wb_wr = 1'b1; in_rd = 5'd9;
        step();
        idle();
        out_ready = 1'b0;
        flush = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h12;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_cycle got rdy=%0b v=%0b exp rdy=0 v=1", in_ready, out_valid);
        end
        step();
        idle();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_drop got=%0b exp=0", out_valid);
        end
        in_valid = 1'b1; in_rs1 = 5'd9; in_rs1_en = 1'b1;
        in_rs2 = 5'd12; in_rs2_en = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_busy_clear got=%0b exp=1", in_ready);
        end
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h0 || out_rs2_val !== 32'h12) begin
            n_fail++;
            $display("[TB] FAIL flush_after got v=%0b rs1=%h rs2=%h exp v=1 rs1=0 rs2=12",
                     out_valid, out_rs1_val, out_rs2_val);
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        out_ready = 1'b0;
        in_valid = 1'b1; in_wb_wr = 1'b1; in_rd = 5'd4; in_fur = 48'hC3;
        step();
        idle();
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1 = 5'd4; in_rs1_en = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset got rdy=%0b v=%0b exp rdy=0 v=1", in_ready, out_valid);
        end
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_rd !== '0 || out_fur !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got v=%0b rd=%0d fur=%h exp v=0 rd=0 fur=0",
                     out_valid, out_rd, out_fur);
        end
        step();
        #3;
        rst_n = 1'b1;
        idle();
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs1_en = 1'b1;
        in_rs2 = 5'd7; in_rs2_en = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL post_reset_ready got=%0b exp=1", in_ready);
        end
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h0 || out_rs2_val !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_regs got v=%0b rs1=%h rs2=%h exp v=1 rs1=0 rs2=0",
                     out_valid, out_rs1_val, out_rs2_val);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_wb_then_read();
        test_bypass_and_zero();
        test_raw_stall();
        test_backpressure();
        test_back_to_back_waw();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
